// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC sequencing, branch redirect with a one-bubble
// penalty, stall hold, and a count of instructions accepted downstream.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_inst,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_valid,
    output logic [31:0] fetch_count
);

    logic [31:0] r_pc;
    logic [31:0] r_out_pc;
    logic        r_out_valid;
    logic [31:0] r_fetch_count;

    logic        w_hold;
    logic        w_accept;
    logic [31:0] w_target;
    logic [31:0] w_pc_inc;

    // A bubble is never held: hold only applies to a valid presented instruction.
    assign w_hold   = stall & r_out_valid & ~branch_taken;
    assign w_accept = r_out_valid & ~stall & ~branch_taken;
    assign w_target = branch_target & 32'hFFFF_FFFC;
    assign w_pc_inc = r_pc + 32'd4;

    // While holding, re-read the presented address so mem_inst stays stable.
    assign mem_addr = reset  ? RESET_PC :
                      w_hold ? r_out_pc : r_pc;

    assign out_inst    = mem_inst;
    assign out_pc      = r_out_pc;
    assign out_valid   = r_out_valid;
    assign fetch_count = r_fetch_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc        <= RESET_PC;
            r_out_pc    <= RESET_PC;
            r_out_valid <= 1'b0;
        end else if (branch_taken) begin
            r_pc        <= w_target;
            r_out_valid <= 1'b0;
        end else if (!w_hold) begin
            r_out_pc    <= r_pc;
            r_out_valid <= 1'b1;
            r_pc        <= w_pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_count <= 32'd0;
        end else if (w_accept) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address of first fetch; bits [1:0] are zero.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port stall  input  1  downstream not accepting the presented instruction.
REQ-005 SHALL have port branch_taken  input  1  redirect fetch this cycle.
REQ-006 SHALL have port branch_target  input  32  redirect byte address; bits [1:0] ignored (forced 0).
REQ-007 SHALL have port mem_addr  output  32  byte address to the code memory; combinational.
REQ-008 SHALL have port mem_inst  input  32  code-memory read data, valid one cycle after mem_addr.
REQ-009 SHALL have port out_inst  output  32  presented instruction; equals mem_inst combinationally.
REQ-010 SHALL have port out_pc  output  32  byte address of out_inst; registered.
REQ-011 SHALL have port out_valid  output  1  out_inst/out_pc hold a correct-path instruction; registered.
REQ-012 SHALL have port fetch_count  output  32  count of instructions accepted downstream; registered.

Function
REQ-013 SHALL hold internal register pc = next address to fetch.
REQ-014 SHALL define hold = stall & out_valid & ~branch_taken.
REQ-015 SHALL drive mem_addr = out_pc when hold, else pc (memory re-reads presented address so mem_inst stays stable next cycle).
REQ-016 Priority per non-reset cycle SHALL be: branch_taken > hold > advance.
REQ-017 branch_taken: pc <= {branch_target[31:2],2'b00}; out_valid <= 0; out_pc held; in-flight fetch squashed.
REQ-018 hold: pc, out_pc, out_valid all unchanged.
REQ-019 advance: out_pc <= pc; out_valid <= 1; pc <= pc + 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-020 stall with out_valid=0 SHALL NOT block advance (bubble is never held).
REQ-021 Branch penalty SHALL be exactly one bubble: branch in cycle b -> out_valid=0 in b+1, out_valid=1 with out_pc=target in b+2 (absent stall/branch).
REQ-022 branch_taken with stall asserted SHALL still redirect and squash; presented instruction discarded.
REQ-023 fetch_count SHALL increment by 1 in cycles where out_valid & ~stall & ~branch_taken; wraps 32'hFFFF_FFFF -> 0.
REQ-024 Back-to-back branch_taken cycles SHALL each redirect; last target wins; out_valid stays 0 until one cycle after last branch.

Reset
REQ-025 reset SHALL override all inputs in the cycle asserted.
REQ-026 On reset: pc <= RESET_PC, out_pc <= RESET_PC, out_valid <= 0, fetch_count <= 0.
REQ-027 During reset, mem_addr SHALL equal RESET_PC.
REQ-028 First cycle after reset release: mem_addr = RESET_PC; next cycle out_valid=1, out_pc=RESET_PC, out_inst=word at RESET_PC.
REQ-029 Reset mid-operation (during hold or after branch) SHALL discard all in-flight state identically to power-up reset.

Verification (memory model: 1-cycle synchronous read, word at byte address A = 32'hC000_0000 + A/4)
REQ-030 Reset 2 cycles, release, no stall, 4 cycles -> out_pc 0,4,8,12 with out_inst C0000000..C0000003, out_valid=1 each; fetch_count=4 after.
REQ-031 Stall 3 cycles while out_pc=8 -> out_pc=8, out_inst=C0000002 held 3 cycles; then 12/C0000003; fetch_count unchanged while stalled.
REQ-032 branch_taken=1, target=32'h0000_0103 while out_pc=4 -> next cycle out_valid=0; following cycle out_pc=0x100, out_inst=C0000040; then 0x104.
REQ-033 branch_taken and stall together at out_pc=8, target 0x40 -> out_valid=0 next cycle, then out_pc=0x40; fetch_count not incremented that cycle.
REQ-034 RESET_PC=32'hFFFF_FFF8, no stall -> out_pc FFFFFFF8, FFFFFFFC, 00000000 (wrap).
REQ-035 Reset asserted during a 2-cycle stall at out_pc=0x20 -> out_valid=0, fetch_count=0, restart at RESET_PC after release.
